// File: rtl/kyber_ntt.sv
// Forward Kyber NTT: loads 256 coefficients as 32 packed words, runs seven in-place
// Cooley-Tukey layers (two cycles per butterfly), then streams the NTT-domain words out.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD    | accepting 32 input words; one drain cycle after the last word
// COMPUTE | 896 butterflies, 2 cycles each; len==0 marks all layers finished
// OUTPUT  | presenting result words under valid/ready
// DONE    | one-cycle done pulse
module kyber_ntt #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int WORDS   = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         valid_in,
  input  logic [127:0] data_in,
  output logic         ready_in,
  output logic [127:0] data_out,
  output logic         valid_out,
  input  logic         ready_out,
  output logic         done
);

  localparam int BARRETT_M = (1 << 26) / KYBER_Q;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, OUTPUT, DONE} state_t;

  // zeta ROM entry k = 17^bitrev7(k) mod q, built at elaboration
  function automatic logic [12*128-1:0] gen_zetas();
    logic [12*128-1:0] tbl;
    int unsigned rev, pw, base;
    tbl = '0;
    for (int i = 0; i < 128; i++) begin
      rev = 0;
      for (int b = 0; b < 7; b++) if (i[b]) rev = rev | (32'd1 << (6 - b));
      pw   = 1;
      base = 17;
      for (int b = 0; b < 7; b++) begin
        if (rev[b]) pw = (pw * base) % KYBER_Q;
        base = (base * base) % KYBER_Q;
      end
      tbl[12*i +: 12] = pw[11:0];
    end
    return tbl;
  endfunction

  localparam logic [12*128-1:0] ZETAS = gen_zetas();

  state_t      state, state_nx;
  logic [11:0] coef [KYBER_N];
  logic [4:0]  wcnt;
  logic [7:0]  len, grp, j_idx;
  logic [6:0]  k_idx;
  logic        phase;
  logic [11:0] a_r, b_r, z_r;

  logic        word_last, load_fire, out_fire, bf_write;
  logic [7:0]  j_hi, grp_end;
  logic [8:0]  grp_nx;
  logic [10:0] z_base;
  logic [11:0] zeta_rd;
  logic [23:0] prod;
  logic [38:0] prod_m;
  logic [12:0] qhat, rem, sum_w;
  logic [11:0] t_mod, sum_mod, diff_mod;
  logic [4:0]  out_sel;
  logic [127:0] out_word;
  logic        unused_lane_hi;

  assign word_last = (wcnt == 5'(WORDS - 1));
  assign load_fire = (state == LOAD) && valid_in && ready_in;
  assign out_fire  = (state == OUTPUT) && valid_out && ready_out;
  assign bf_write  = (state == COMPUTE) && (len != 8'd0) && phase;
  assign done      = (state == DONE);

  assign j_hi    = j_idx + len;
  assign grp_end = grp + len - 8'd1;
  assign grp_nx  = {1'b0, grp} + {len, 1'b0};
  assign z_base  = 11'(k_idx) * 11'd12;
  assign zeta_rd = ZETAS[z_base +: 12];

  // Barrett: qhat is floor(prod/q) or one less, so a single subtract finishes it
  assign prod     = 24'(z_r) * 24'(b_r);
  assign prod_m   = 39'(prod) * 39'(BARRETT_M);
  assign qhat     = 13'(prod_m >> 26);
  assign rem      = 13'(prod - 24'(qhat) * 24'(KYBER_Q));
  assign t_mod    = (rem >= 13'(KYBER_Q)) ? 12'(rem - 13'(KYBER_Q)) : rem[11:0];
  assign sum_w    = {1'b0, a_r} + {1'b0, t_mod};
  assign sum_mod  = (sum_w >= 13'(KYBER_Q)) ? 12'(sum_w - 13'(KYBER_Q)) : sum_w[11:0];
  assign diff_mod = (a_r >= t_mod) ? (a_r - t_mod)
                                   : 12'({1'b0, a_r} + 13'(KYBER_Q) - {1'b0, t_mod});

  always_comb begin
    out_sel  = (state == OUTPUT) ? wcnt + 5'd1 : 5'd0;
    out_word = '0;
    for (int i = 0; i < 8; i++) out_word[16*i +: 12] = coef[{out_sel, 3'(i)}];
  end

  always_comb begin
    unused_lane_hi = 1'b0;
    for (int i = 0; i < 8; i++) unused_lane_hi = unused_lane_hi ^ (^data_in[16*i+12 +: 4]);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (!ready_in) state_nx = COMPUTE;
      COMPUTE: if (len == 8'd0) state_nx = OUTPUT;
      OUTPUT:  if (out_fire && word_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready_in  <= 1'b0;
      valid_out <= 1'b0;
      data_out  <= '0;
      wcnt      <= '0;
      len       <= '0;
      grp       <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      phase     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      z_r       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start) begin
          ready_in <= 1'b1;
          wcnt     <= '0;
        end
        LOAD: if (load_fire) begin
          wcnt <= wcnt + 5'd1;
          if (word_last) begin
            ready_in <= 1'b0;
            len      <= 8'd128;
            grp      <= '0;
            j_idx    <= '0;
            k_idx    <= 7'd1;
            phase    <= 1'b0;
          end
        end
        COMPUTE: begin
          if (len == 8'd0) begin
            valid_out <= 1'b1;
            data_out  <= out_word;
          end else if (!phase) begin
            phase <= 1'b1;
            a_r   <= coef[j_idx];
            b_r   <= coef[j_hi];
            z_r   <= zeta_rd;
          end else begin
            phase <= 1'b0;
            if (j_idx == grp_end) begin
              k_idx <= k_idx + 7'd1;
              if (grp_nx[8]) begin
                len   <= (len == 8'd2) ? 8'd0 : (len >> 1);
                grp   <= '0;
                j_idx <= '0;
              end else begin
                grp   <= grp_nx[7:0];
                j_idx <= grp_nx[7:0];
              end
            end else begin
              j_idx <= j_idx + 8'd1;
            end
          end
        end
        OUTPUT: if (out_fire) begin
          if (word_last) begin
            valid_out <= 1'b0;
            wcnt      <= '0;
          end else begin
            wcnt     <= wcnt + 5'd1;
            data_out <= out_word;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int i = 0; i < 8; i++) coef[{wcnt, 3'(i)}] <= data_in[16*i +: 12];
    end else if (bf_write) begin
      coef[j_idx] <= sum_mod;
      coef[j_hi]  <= diff_mod;
    end
  end

endmodule

// File: tb/tb_kyber_ntt.sv
// Scoreboard bench for kyber_ntt: expected words are queued when a transform is issued
// and a negedge monitor pops and compares every accepted output word.
module tb_kyber_ntt;
  localparam int Q = 3329;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         valid_in = 1'b0;
  logic [127:0] data_in = '0;
  logic         ready_in;
  logic [127:0] data_out;
  logic         valid_out;
  logic         ready_out = 1'b0;
  logic         done;

  kyber_ntt dut (
    .clk(clk), .reset_n(reset_n), .start(start), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bp_pct = 0;
  int done_cnt = 0;
  int first_valid_cyc = 0;
  logic prev_valid = 1'b0;
  logic stall_prev = 1'b0;
  logic [127:0] held = '0;
  logic [127:0] exp_q[$];
  int cur[256];
  int expv[256];
  int pw[256];

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    ready_out = (int'($urandom_range(0, 99)) >= bp_pct);
  end

  task automatic chk_w(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // monitor: scoreboard pop on each accepted word, hold check on each stalled word
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (valid_out) begin
      if (stall_prev) chk_w("stall_hold", data_out, held);
      if (!prev_valid) first_valid_cyc = cyc;
      if (ready_out) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%h required=none", data_out);
        end else begin
          chk_w("data_out", data_out, exp_q.pop_front());
        end
      end
      stall_prev = !ready_out;
      held       = data_out;
    end else begin
      stall_prev = 1'b0;
    end
    prev_valid = valid_out;
  end

  function automatic int brv7(input int x);
    int r = 0;
    for (int b = 0; b < 7; b++) if (x[b]) r = r | (1 << (6 - b));
    return r;
  endfunction

  // definitional NTT: output pair i is f mod (X^2 - zeta^(2*brv7(i)+1))
  task automatic model_ntt();
    for (int i = 0; i < 128; i++) begin
      int g = 2 * brv7(i) + 1;
      int se = 0;
      int so = 0;
      for (int j = 0; j < 128; j++) begin
        int z = pw[(g * j) % 256];
        se = (se + cur[2*j] * z) % Q;
        so = (so + cur[2*j+1] * z) % Q;
      end
      expv[2*i]   = se;
      expv[2*i+1] = so;
    end
  endtask

  function automatic logic [127:0] word_of_cur(input int w);
    logic [127:0] r = '0;
    for (int l = 0; l < 8; l++) r[16*l +: 16] = 16'(cur[8*w+l]);
    return r;
  endfunction

  function automatic logic [127:0] word_of_exp(input int w);
    logic [127:0] r = '0;
    for (int l = 0; l < 8; l++) r[16*l +: 16] = 16'(expv[8*w+l]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_poly(input int gap_pct, input bit poke, input bit push_exp, output int c0);
    int guard;
    if (push_exp) for (int w = 0; w < 32; w++) exp_q.push_back(word_of_exp(w));
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 32; w++) begin
      guard = 0;
      while (int'($urandom_range(0, 99)) < gap_pct && guard < 6) begin
        valid_in = 1'b0;
        tick();
        guard++;
      end
      if (poke && w == 10) begin
        valid_in = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      valid_in = 1'b1;
      data_in  = word_of_cur(w);
      guard = 0;
      @(negedge clk);
      while (!ready_in && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!ready_in) chk_i("load_ready_timeout", int'(ready_in), 1);
      tick();
    end
    valid_in = 1'b0;
    data_in  = '0;
    c0 = cyc;
  endtask

  task automatic finish_poly(input bit poke, input int c0);
    int guard = 0;
    int dc0 = done_cnt;
    bit poked = 1'b0;
    if (poke) begin
      repeat (100) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    while (!done && guard < 6000) begin
      @(negedge clk);
      guard++;
      if (poke && !poked && valid_out) begin
        poked = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    chk_i("done_seen", int'(done), 1);
    chk_i("latency", first_valid_cyc - c0, 1794);
    repeat (5) @(negedge clk);
    chk_i("done_pulses", done_cnt - dc0, 1);
    chk_i("exp_q_drained", exp_q.size(), 0);
    chk_i("idle_ready_in", int'(ready_in), 0);
  endtask

  task automatic run_poly(input int gap_pct, input int bp, input bit poke);
    int c0;
    bp_pct = bp;
    load_poly(gap_pct, poke, 1'b1, c0);
    finish_poly(poke, c0);
  endtask

  task automatic random_poly();
    for (int i = 0; i < 256; i++) cur[i] = int'($urandom_range(0, Q - 1));
  endtask

  initial begin
    #950_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    bit seen;
    int c0;
    pw[0] = 1;
    for (int e = 1; e < 256; e++) pw[e] = (pw[e-1] * 17) % Q;

    repeat (3) @(posedge clk);
    #2;
    chk_i("rst_ready_in", int'(ready_in), 0);
    chk_i("rst_valid_out", int'(valid_out), 0);
    chk_i("rst_done", int'(done), 0);
    chk_w("rst_data_out", data_out, '0);
    tick();
    reset_n = 1'b1;

    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (ready_in || valid_out || done) seen = 1'b1;
    end
    chk_i("idle_quiet", int'(seen), 0);
    tick();

    // delta at 0: every residue pair becomes (1, 0)
    for (int i = 0; i < 256; i++) cur[i] = 0;
    cur[0] = 1;
    for (int i = 0; i < 256; i++) expv[i] = (i % 2 == 0) ? 1 : 0;
    run_poly(0, 0, 1'b0);

    // delta at 128: X^128 = (X^2)^64 -> zeta^(64*(2*brv7(i)+1)) = 1729 for i<64, else 1600
    for (int i = 0; i < 256; i++) cur[i] = 0;
    cur[128] = 1;
    for (int i = 0; i < 128; i++) begin
      expv[2*i]   = (i < 64) ? 1729 : 1600;
      expv[2*i+1] = 0;
    end
    run_poly(30, 30, 1'b0);

    for (int i = 0; i < 256; i++) cur[i] = Q - 1;
    model_ntt();
    run_poly(0, 50, 1'b0);

    random_poly();
    model_ntt();
    run_poly(20, 30, 1'b1);

    random_poly();
    bp_pct = 0;
    load_poly(0, 1'b0, 1'b0, c0);
    repeat (300) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_i("midrst_ready_in", int'(ready_in), 0);
    chk_i("midrst_valid_out", int'(valid_out), 0);
    chk_i("midrst_done", int'(done), 0);
    chk_w("midrst_data_out", data_out, '0);
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (2100) begin
      @(negedge clk);
      if (ready_in || valid_out || done) seen = 1'b1;
    end
    chk_i("midrst_no_output", int'(seen), 0);
    tick();

    for (int n = 0; n < 20; n++) begin
      random_poly();
      model_ntt();
      run_poly(20, 30, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
